// File: rtl/mig_rw_scheduler_pkg.sv
// ============================================================================
//  Module      : mig_sched_pkg
//  Description : Shared types and command encodings for the MIG read/write
//                scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mig_sched_pkg;

  // Scheduler FSM states; IDLE doubles as the bus turnaround slot.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } sched_state_t;

  // Which stream was granted most recently.
  typedef enum logic {
    STREAM_WR = 1'b0,
    STREAM_RD = 1'b1
  } stream_t;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // MIG command code driven while in a given state (IDLE shows the write code,
  // app_en is low there so the value is never consumed).
  function automatic logic [2:0] cmd_for_state(input sched_state_t s);
    return (s == READ) ? CMD_READ : CMD_WRITE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mig_rw_scheduler_if.sv
// ============================================================================
//  Module      : mig_rw_scheduler_if
//  Description : Bundle of stream-side and MIG app-side signals seen by the
//                scheduler. master = scheduler, slave = surrounding logic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mig_rw_scheduler_if #(
  parameter int WORD_W = 128,
  parameter int ADDR_W = 27
);

  // stream side
  logic              wr_sync_in;
  logic              rd_sync_in;
  logic              wr_valid_in;
  logic [WORD_W-1:0] wr_data_in;
  logic              wr_pop_out;
  logic              rd_enable_in;
  logic [7:0]        rd_free_in;
  logic [WORD_W-1:0] rd_data_out;
  logic              rd_valid_out;

  // MIG app side
  logic              app_rdy_in;
  logic              app_wdf_rdy_in;
  logic              app_rd_data_valid_in;
  logic [WORD_W-1:0] app_rd_data_in;
  logic              app_en_out;
  logic              app_wdf_wren_out;
  logic              app_wdf_end_out;
  logic [2:0]        app_cmd_out;
  logic [ADDR_W-1:0] app_addr_out;
  logic [WORD_W-1:0] app_wdf_data_out;

  // status
  logic              wr_frame_done_out;
  logic              rd_frame_done_out;
  logic [31:0]       wr_cmd_count_out;
  logic [31:0]       rd_cmd_count_out;

  modport master (
    input  wr_sync_in, rd_sync_in, wr_valid_in, wr_data_in, rd_enable_in,
           rd_free_in, app_rdy_in, app_wdf_rdy_in, app_rd_data_valid_in,
           app_rd_data_in,
    output wr_pop_out, rd_data_out, rd_valid_out, app_en_out,
           app_wdf_wren_out, app_wdf_end_out, app_cmd_out, app_addr_out,
           app_wdf_data_out, wr_frame_done_out, rd_frame_done_out,
           wr_cmd_count_out, rd_cmd_count_out
  );

  modport slave (
    output wr_sync_in, rd_sync_in, wr_valid_in, wr_data_in, rd_enable_in,
           rd_free_in, app_rdy_in, app_wdf_rdy_in, app_rd_data_valid_in,
           app_rd_data_in,
    input  wr_pop_out, rd_data_out, rd_valid_out, app_en_out,
           app_wdf_wren_out, app_wdf_end_out, app_cmd_out, app_addr_out,
           app_wdf_data_out, wr_frame_done_out, rd_frame_done_out,
           wr_cmd_count_out, rd_cmd_count_out
  );

endinterface

`default_nettype wire

// File: rtl/mig_rw_scheduler_frame_addr_gen.sv
// ============================================================================
//  Module      : frame_addr_gen
//  Description : Wrapping frame address counter. Advances by ADDR_STRIDE per
//                step, wraps to 0 after FRAME_WORDS steps with a one-cycle
//                wrap pulse, and restarts at 0 on sync (no pulse).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_addr_gen #(
  parameter int FRAME_WORDS = 38400,
  parameter int ADDR_STRIDE = 8,
  parameter int ADDR_W      = 27
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic              sync,
  output logic [ADDR_W-1:0] addr,
  output logic              wrap_pulse
);

  // One extra bit so the last increment is compared without truncation.
  localparam logic [ADDR_W:0] WRAP_AT = (ADDR_W+1)'(FRAME_WORDS * ADDR_STRIDE);
  localparam logic [ADDR_W:0] STRIDE  = (ADDR_W+1)'(ADDR_STRIDE);

  logic [ADDR_W:0] addr_inc;

  assign addr_inc = {1'b0, addr} + STRIDE;

  // Address register: sync wins over a same-cycle step, wrap raises the pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr       <= '0;
      wrap_pulse <= 1'b0;
    end else if (sync) begin
      addr       <= '0;
      wrap_pulse <= 1'b0;
    end else if (step) begin
      if (addr_inc >= WRAP_AT) begin
        addr       <= '0;
        wrap_pulse <= 1'b1;
      end else begin
        addr       <= addr_inc[ADDR_W-1:0];
        wrap_pulse <= 1'b0;
      end
    end else begin
      wrap_pulse <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mig_rw_scheduler.sv
// ============================================================================
//  Module      : mig_rw_scheduler
//  Description : Shares one MIG UI port between a write stream and a read
//                stream: alternating bursts with an IDLE turnaround, wrapping
//                frame addresses, read-credit tracking and frame-done pulses.
//                Optional command statistics: define MIG_SCHED_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mig_rw_scheduler
  import mig_sched_pkg::*;
#(
  parameter int FRAME_WORDS = 38400,
  parameter int ADDR_W      = 27,
  parameter int ADDR_STRIDE = 8,
  parameter int WORD_W      = 128,
  parameter int BURST_MAX   = 16,
  parameter int RD_CREDITS  = 32
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  mig_rw_scheduler_if.master  bus
);

  localparam int          CNT_W       = $clog2(RD_CREDITS + 1);
  localparam int          BURST_W     = $clog2(BURST_MAX + 1);
  localparam logic [31:0] CREDIT_LIM  = 32'(RD_CREDITS);
  localparam logic [31:0] BURST_LIM   = 32'(BURST_MAX);

  sched_state_t       state;
  sched_state_t       state_next;
  stream_t            last_served;
  logic [BURST_W-1:0] burst_cnt;
  logic [BURST_W-1:0] burst_inc;
  logic [BURST_W-1:0] burst_after;
  logic               burst_hit;
  logic [CNT_W-1:0]   outstanding;

  logic               wr_want;
  logic               rd_want;
  logic               wr_accept;
  logic               rd_accept;
  logic               any_accept;

  logic [ADDR_W-1:0]  wr_addr;
  logic [ADDR_W-1:0]  rd_addr;
  logic [WORD_W-1:0]  wr_word;

  logic               app_en;
  logic               wdf_wren;
  logic               wr_pop;
  logic [ADDR_W-1:0]  app_addr;

  // ---------------------------------------------------------------------------
  // Request qualification
  // ---------------------------------------------------------------------------
  assign wr_want = bus.wr_valid_in;
  assign rd_want = bus.rd_enable_in
                && (32'(outstanding) < CREDIT_LIM)
                && (32'(outstanding) < 32'(bus.rd_free_in));

  assign wr_accept  = (state == WRITE) && bus.wr_valid_in && bus.app_rdy_in
                   && bus.app_wdf_rdy_in;
  assign rd_accept  = (state == READ) && rd_want && bus.app_rdy_in;
  assign any_accept = wr_accept || rd_accept;

  // Burst length including this cycle's accept, so the burst ends on exactly
  // BURST_MAX commands rather than one more.
  assign burst_inc   = (32'(burst_cnt) < BURST_LIM) ? burst_cnt + BURST_W'(1) : burst_cnt;
  assign burst_after = any_accept ? burst_inc : burst_cnt;
  assign burst_hit   = (32'(burst_after) >= BURST_LIM);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // State, burst counter and fairness bookkeeping.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state       <= IDLE;
      burst_cnt   <= '0;
      last_served <= STREAM_RD;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next != IDLE) begin
        burst_cnt <= '0;
      end else if (any_accept) begin
        burst_cnt <= burst_inc;
      end
      if (wr_accept) begin
        last_served <= STREAM_WR;
      end else if (rd_accept) begin
        last_served <= STREAM_RD;
      end
    end
  end

  // Next-state decision and MIG strobes, all derived from the current state.
  always_comb begin
    state_next = state;
    app_en     = 1'b0;
    wdf_wren   = 1'b0;
    wr_pop     = 1'b0;
    app_addr   = '0;
    unique case (state)
      IDLE: begin
        if (wr_want && rd_want) begin
          state_next = (last_served == STREAM_WR) ? READ : WRITE;
        end else if (wr_want) begin
          state_next = WRITE;
        end else if (rd_want) begin
          state_next = READ;
        end
      end
      WRITE: begin
        app_en   = bus.wr_valid_in && bus.app_wdf_rdy_in;
        wdf_wren = bus.wr_valid_in && bus.app_rdy_in;
        wr_pop   = wr_accept;
        app_addr = wr_addr;
        if (!wr_want || (burst_hit && rd_want)) begin
          state_next = IDLE;
        end
      end
      READ: begin
        app_en   = rd_want;
        app_addr = rd_addr;
        if (!rd_want || (burst_hit && wr_want)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outstanding read credits; floor at 0 so stale returns after reset are safe
  // ---------------------------------------------------------------------------
  // Credit counter: +1 per read command, -1 per returned beat.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      outstanding <= '0;
    end else begin
      case ({rd_accept, bus.app_rd_data_valid_in})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   if (outstanding != '0) outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Per-stream frame address generators
  // ---------------------------------------------------------------------------
  frame_addr_gen #(
    .FRAME_WORDS (FRAME_WORDS),
    .ADDR_STRIDE (ADDR_STRIDE),
    .ADDR_W      (ADDR_W)
  ) u_wr_addr (
    .clk        (clk_in),
    .rst_n      (rst_n_in),
    .step       (wr_accept),
    .sync       (bus.wr_sync_in),
    .addr       (wr_addr),
    .wrap_pulse (bus.wr_frame_done_out)
  );

  frame_addr_gen #(
    .FRAME_WORDS (FRAME_WORDS),
    .ADDR_STRIDE (ADDR_STRIDE),
    .ADDR_W      (ADDR_W)
  ) u_rd_addr (
    .clk        (clk_in),
    .rst_n      (rst_n_in),
    .step       (rd_accept),
    .sync       (bus.rd_sync_in),
    .addr       (rd_addr),
    .wrap_pulse (bus.rd_frame_done_out)
  );

  // ---------------------------------------------------------------------------
  // Output wiring
  // ---------------------------------------------------------------------------
  assign wr_word              = bus.wr_data_in;
  assign bus.app_wdf_data_out = wr_word;
  assign bus.app_en_out       = app_en;
  assign bus.app_wdf_wren_out = wdf_wren;
  assign bus.app_wdf_end_out  = wdf_wren;
  assign bus.wr_pop_out       = wr_pop;
  assign bus.app_addr_out     = app_addr;
  assign bus.app_cmd_out      = cmd_for_state(state);

  // Read data is a straight pass-through, independent of scheduler state.
  assign bus.rd_valid_out     = bus.app_rd_data_valid_in;
  assign bus.rd_data_out      = bus.app_rd_data_in;

  // ---------------------------------------------------------------------------
  // Command statistics
  // ---------------------------------------------------------------------------
`ifdef MIG_SCHED_STATS_EN
  logic [31:0] wr_cmd_cnt;
  logic [31:0] rd_cmd_cnt;

  // Free-running accepted-command counters, cleared only by reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      wr_cmd_cnt <= '0;
      rd_cmd_cnt <= '0;
    end else begin
      if (wr_accept) wr_cmd_cnt <= wr_cmd_cnt + 32'd1;
      if (rd_accept) rd_cmd_cnt <= rd_cmd_cnt + 32'd1;
    end
  end

  assign bus.wr_cmd_count_out = wr_cmd_cnt;
  assign bus.rd_cmd_count_out = rd_cmd_cnt;
`else
  assign bus.wr_cmd_count_out = '0;
  assign bus.rd_cmd_count_out = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mig_rw_scheduler.sv
// ============================================================================
//  Module      : tb_mig_rw_scheduler
//  Description : Self-checking bench for mig_rw_scheduler (FRAME_WORDS=4,
//                BURST_MAX=4): strobe vector table plus command/read-data
//                scoreboards driven by hand-written sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mig_rw_scheduler;

  localparam int WORD_W = 128;
  localparam int ADDR_W = 27;
  localparam int FW     = 4;
  localparam int BM     = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mig_rw_scheduler_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

  mig_rw_scheduler #(
    .FRAME_WORDS (FW),
    .ADDR_W      (ADDR_W),
    .ADDR_STRIDE (8),
    .WORD_W      (WORD_W),
    .BURST_MAX   (BM),
    .RD_CREDITS  (32)
  ) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  int errors = 0;
  int checks = 0;
  int n_wr_acc = 0;
  int n_rd_acc = 0;
  int n_pop = 0;

  typedef struct {
    logic [2:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } cmd_exp_t;

  cmd_exp_t          cq[$];
  logic [WORD_W-1:0] rq[$];
  cmd_exp_t          m_e;
  logic [WORD_W-1:0] m_rd;

  typedef struct {
    logic       rst_n;
    logic       wr_valid;
    logic       app_rdy;
    logic       wdf_rdy;
    logic       rd_en;
    logic [7:0] rd_free;
    logic       rd_ret;
    logic       e_en;
    logic       e_wren;
    logic       e_pop;
    logic       e_rdv;
    logic       chk_cmd;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic [2:0] c, input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
    cmd_exp_t e;
    e.cmd  = c;
    e.addr = a;
    e.data = d;
    cq.push_back(e);
  endtask

  task automatic drive_idle();
    bus.wr_sync_in           = 1'b0;
    bus.rd_sync_in           = 1'b0;
    bus.wr_valid_in          = 1'b0;
    bus.wr_data_in           = '0;
    bus.rd_enable_in         = 1'b0;
    bus.rd_free_in           = 8'd0;
    bus.app_rdy_in           = 1'b0;
    bus.app_wdf_rdy_in       = 1'b0;
    bus.app_rd_data_valid_in = 1'b0;
    bus.app_rd_data_in       = '0;
  endtask

  // Hold reset for one edge; returns at posedge+1 with the DUT in IDLE.
  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: command acceptances and forwarded read data.
  always @(negedge clk) begin
    if (bus.rd_valid_out) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_fwd: unexpected rd_valid_out data %0h", bus.rd_data_out);
      end else begin
        m_rd = rq.pop_front();
        check("rd_fwd_data", bus.rd_data_out, m_rd);
      end
    end
    if (rst_n && bus.app_en_out && bus.app_rdy_in) begin
      if (bus.app_cmd_out == 3'b001) n_rd_acc++;
      else n_wr_acc++;
      if (cq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cmd_unexpected: got cmd %0h addr %0h, none expected", bus.app_cmd_out, bus.app_addr_out);
      end else begin
        m_e = cq.pop_front();
        check("cmd_type", bus.app_cmd_out, m_e.cmd);
        check("cmd_addr", bus.app_addr_out, m_e.addr);
        if (m_e.cmd == 3'b000) begin
          check("wr_pop", bus.wr_pop_out, 1'b1);
          check("wdf_wren", bus.app_wdf_wren_out, 1'b1);
          check("wdf_end", bus.app_wdf_end_out, 1'b1);
          check("wdf_data", bus.app_wdf_data_out, m_e.data);
        end
      end
    end
    if (rst_n && bus.wr_pop_out) n_pop++;
  end

  initial begin
    int n0;
    logic [WORD_W-1:0] wd;
    logic [ADDR_W-1:0] wa;
    logic [ADDR_W-1:0] ra;

    //                 rst wv ar wr re free ret  en wren pop rdv cmd
    vt[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd8,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd4,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    drive_idle();
    @(posedge clk);
    #1;

    // ---- vector table: IDLE under reset, then WRITE-state strobes ----
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        // enter WRITE without an accept
        rst_n              = 1'b1;
        bus.wr_valid_in    = 1'b1;
        bus.app_rdy_in     = 1'b0;
        bus.app_wdf_rdy_in = 1'b0;
        bus.rd_enable_in   = 1'b0;
        bus.app_rd_data_valid_in = 1'b0;
        @(posedge clk);
        #1;
      end
      rst_n                    = vt[i].rst_n;
      bus.wr_valid_in          = vt[i].wr_valid;
      bus.app_rdy_in           = vt[i].app_rdy;
      bus.app_wdf_rdy_in       = vt[i].wdf_rdy;
      bus.rd_enable_in         = vt[i].rd_en;
      bus.rd_free_in           = vt[i].rd_free;
      bus.app_rd_data_valid_in = vt[i].rd_ret;
      bus.app_rd_data_in       = 128'(32'hA5A5_0000 + i);
      if (vt[i].rd_ret) rq.push_back(128'(32'hA5A5_0000 + i));
      @(negedge clk);
      check($sformatf("vec%0d_app_en", i), bus.app_en_out, vt[i].e_en);
      check($sformatf("vec%0d_wdf_wren", i), bus.app_wdf_wren_out, vt[i].e_wren);
      check($sformatf("vec%0d_wr_pop", i), bus.wr_pop_out, vt[i].e_pop);
      check($sformatf("vec%0d_rd_valid", i), bus.rd_valid_out, vt[i].e_rdv);
      if (vt[i].chk_cmd) check($sformatf("vec%0d_cmd", i), bus.app_cmd_out, 3'b000);
      @(posedge clk);
      #1;
    end

    // ---- three writes at 0, 8, 16 ----
    do_reset();
    wd = {32'hDEAD_BEEF, 96'h1};
    bus.wr_data_in = wd;
    bus.app_rdy_in = 1'b1;
    bus.app_wdf_rdy_in = 1'b1;
    n0 = n_pop;
    for (int c = 0; c < 6; c++) begin
      bus.wr_valid_in = (c <= 3);
      if (c >= 1 && c <= 3) push_cmd(3'b000, ADDR_W'((c - 1) * 8), wd);
      @(negedge clk);
      if (c == 0) check("reset_idle_app_en", bus.app_en_out, 1'b0);
      @(posedge clk);
      #1;
    end
    check("three_writes_pop_count", 32'(n_pop - n0), 32'd3);

    // ---- burst alternation, both streams always want ----
    do_reset();
    wd = {32'hB0B0_B0B0, 96'h2};
    bus.wr_data_in     = wd;
    bus.wr_valid_in    = 1'b1;
    bus.rd_enable_in   = 1'b1;
    bus.rd_free_in     = 8'd255;
    bus.app_rdy_in     = 1'b1;
    bus.app_wdf_rdy_in = 1'b1;
    wa = '0;
    ra = '0;
    for (int c = 0; c < 25; c++) begin
      int p;
      p = c % 10;
      if (p >= 1 && p <= 4) begin
        push_cmd(3'b000, wa, wd);
        wa = ADDR_W'((wa + 8) % (FW * 8));
      end
      if (p >= 6) begin
        push_cmd(3'b001, ra, '0);
        ra = ADDR_W'((ra + 8) % (FW * 8));
      end
      @(negedge clk);
      check($sformatf("burst_c%0d_app_en", c), bus.app_en_out, (p != 0 && p != 5));
      if (p != 0 && p != 5) check($sformatf("burst_c%0d_cmd", c), bus.app_cmd_out, (p >= 6) ? 3'b001 : 3'b000);
      @(posedge clk);
      #1;
    end

    // ---- read credits limited by rd_free_in = 2 ----
    do_reset();
    bus.rd_enable_in = 1'b1;
    bus.rd_free_in   = 8'd2;
    bus.app_rdy_in   = 1'b1;
    bus.app_wdf_rdy_in = 1'b1;
    n0 = n_rd_acc;
    for (int c = 0; c < 6; c++) begin
      if (c == 1 || c == 2) push_cmd(3'b001, ADDR_W'((c - 1) * 8), '0);
      @(negedge clk);
      if (c == 5) check("credit_stall_app_en", bus.app_en_out, 1'b0);
      @(posedge clk);
      #1;
    end
    check("credit_two_reads", 32'(n_rd_acc - n0), 32'd2);
    n0 = n_rd_acc;
    for (int r = 0; r < 6; r++) begin
      bus.app_rd_data_valid_in = (r == 0);
      bus.app_rd_data_in       = 128'h1234_5678;
      if (r == 0) rq.push_back(128'h1234_5678);
      if (r == 2) push_cmd(3'b001, ADDR_W'(16), '0);
      @(negedge clk);
      if (r == 5) check("credit_restall_app_en", bus.app_en_out, 1'b0);
      @(posedge clk);
      #1;
    end
    check("credit_one_more_read", 32'(n_rd_acc - n0), 32'd1);

    // ---- address wrap with FRAME_WORDS = 4 ----
    do_reset();
    wd = {32'hC0DE_0000, 96'h3};
    bus.wr_data_in     = wd;
    bus.wr_valid_in    = 1'b1;
    bus.app_rdy_in     = 1'b1;
    bus.app_wdf_rdy_in = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c >= 1) push_cmd(3'b000, ADDR_W'(((c - 1) % 4) * 8), wd);
      @(negedge clk);
      check($sformatf("wrap_c%0d_wr_done", c), bus.wr_frame_done_out, (c == 5));
      check($sformatf("wrap_c%0d_rd_done", c), bus.rd_frame_done_out, 1'b0);
      @(posedge clk);
      #1;
    end

    // ---- write sync coinciding with the accept at 16 ----
    do_reset();
    wd = {32'h5157_0000, 96'h4};
    bus.wr_data_in     = wd;
    bus.wr_valid_in    = 1'b1;
    bus.app_rdy_in     = 1'b1;
    bus.app_wdf_rdy_in = 1'b1;
    for (int c = 0; c < 7; c++) begin
      bus.wr_sync_in = (c == 3);
      if (c >= 1) push_cmd(3'b000, (c <= 3) ? ADDR_W'((c - 1) * 8) : ADDR_W'((c - 4) * 8), wd);
      @(negedge clk);
      check($sformatf("sync_c%0d_wr_done", c), bus.wr_frame_done_out, 1'b0);
      @(posedge clk);
      #1;
    end
    bus.wr_sync_in = 1'b0;

    // ---- reset with three reads outstanding, late returns ----
    do_reset();
    bus.rd_enable_in = 1'b1;
    bus.rd_free_in   = 8'd3;
    bus.app_rdy_in   = 1'b1;
    bus.app_wdf_rdy_in = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c >= 1 && c <= 3) push_cmd(3'b001, ADDR_W'((c - 1) * 8), '0);
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    do_reset();
    bus.app_rdy_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.app_rd_data_valid_in = 1'b1;
      bus.app_rd_data_in       = 128'(32'hF00D_0000 + k);
      rq.push_back(128'(32'hF00D_0000 + k));
      @(negedge clk);
      check($sformatf("late_ret%0d_idle_app_en", k), bus.app_en_out, 1'b0);
      check($sformatf("late_ret%0d_idle_wren", k), bus.app_wdf_wren_out, 1'b0);
      check($sformatf("late_ret%0d_rd_valid", k), bus.rd_valid_out, 1'b1);
      @(posedge clk);
      #1;
    end
    bus.app_rd_data_valid_in = 1'b0;
    bus.rd_enable_in = 1'b1;
    bus.rd_free_in   = 8'd1;
    n0 = n_rd_acc;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) push_cmd(3'b001, '0, '0);
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    check("post_reset_one_read", 32'(n_rd_acc - n0), 32'd1);

    drive_idle();
    @(negedge clk);
    check("cmd_queue_drained", 32'(cq.size()), 32'd0);
    check("rd_queue_drained", 32'(rq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
